// File: rtl/router_pkg.sv
// Shared constants and arbitration helper for the 4-port router.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 2;

    // Returns {found, index} of the first set request at or after start.
    function automatic logic [ADDR_W:0] pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [ADDR_W-1:0]    start
    );
        logic [ADDR_W:0]   r;
        logic [ADDR_W-1:0] idx;
        r = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = start + ADDR_W'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO with full/empty flags; a pop frees a slot for a same-edge push.
module router_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/router.sv
// 4x4 buffered crossbar router; ROUTER_RR_ARB_EN selects round-robin
// output arbitration, otherwise lowest input index wins.
module router
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in     [NUM_PORTS-1:0],
    input  logic [ADDR_W-1:0]     destination [NUM_PORTS-1:0],
    output logic [DATA_WIDTH-1:0] data_out    [NUM_PORTS-1:0],
    output logic                  valid       [NUM_PORTS-1:0]
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_W-1:0]     dest;
    } entry_t;

    entry_t               head  [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] req   [NUM_PORTS];
    logic [ADDR_W:0]      gnt   [NUM_PORTS];
    logic                 unused_full;

    assign unused_full = &full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        router_fifo #(
            .W     ($bits(entry_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (1'b1),
            .pop   (pop[i]),
            .wdata ({data_in[i], destination[i]}),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

`ifdef ROUTER_RR_ARB_EN
    logic [ADDR_W-1:0] ptr [NUM_PORTS];
`endif

    // req[j][i]: head of input i wants output j
    always_comb begin
        pop = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            req[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[j][i] = !empty[i] && (head[i].dest == ADDR_W'(j));
            end
`ifdef ROUTER_RR_ARB_EN
            gnt[j] = pick(req[j], ptr[j]);
`else
            gnt[j] = pick(req[j], '0);
`endif
            if (gnt[j][ADDR_W]) pop[gnt[j][ADDR_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                data_out[j] <= '0;
                valid[j]    <= 1'b0;
            end
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                valid[j] <= gnt[j][ADDR_W];
                if (gnt[j][ADDR_W]) begin
                    data_out[j] <= head[gnt[j][ADDR_W-1:0]].data;
                end
            end
        end
    end

`ifdef ROUTER_RR_ARB_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUM_PORTS; j++) ptr[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (gnt[j][ADDR_W]) ptr[j] <= gnt[j][ADDR_W-1:0] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router.sv
// Bench for router: queue-based reference model, vector table and corner sequences.
module tb_router;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in     [3:0];
    logic [1:0]    destination [3:0];
    logic [DW-1:0] data_out    [3:0];
    logic          valid       [3:0];

    router #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .destination (destination),
        .data_out    (data_out),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    t;
    } word_t;

    word_t         q [4][$];
    logic [DW-1:0] m_data  [4];
    logic          m_valid [4];
    int            m_ptr   [4];

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_ptr[i]   = 0;
        end
    endtask

    task automatic m_step();
        int win [4];
        int start;
        int idx;
        for (int j = 0; j < 4; j++) begin
            win[j] = -1;
`ifdef ROUTER_RR_ARB_EN
            start = m_ptr[j];
`else
            start = 0;
`endif
            for (int k = 0; k < 4; k++) begin
                idx = (start + k) % 4;
                if (win[j] < 0 && q[idx].size() > 0 && int'(q[idx][0].t) == j)
                    win[j] = idx;
            end
        end
        for (int j = 0; j < 4; j++) begin
            m_valid[j] = (win[j] >= 0);
            if (win[j] >= 0) begin
                m_data[j] = q[win[j]][0].d;
                void'(q[win[j]].pop_front());
                m_ptr[j] = (win[j] + 1) % 4;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() < DEPTH) q[i].push_back({data_in[i], destination[i]});
        end
    endtask

    task automatic expect_eq(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic check_model(string tag);
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (valid[j] !== m_valid[j] || data_out[j] !== m_data[j]) begin
                fails++;
                $display("FAIL %s port%0d: got valid=%0b data=%02h, want valid=%0b data=%02h",
                         tag, j, valid[j], data_out[j], m_valid[j], m_data[j]);
            end
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        if (rst) m_step();
        else     m_reset();
        #1;
        check_model(tag);
    endtask

    task automatic drive_all(logic [DW-1:0] d, logic [1:0] t);
        for (int i = 0; i < 4; i++) begin
            data_in[i]     = d;
            destination[i] = t;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        cycle("reset");
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0][DW-1:0] din;
        logic [3:0][1:0]    dst;
        logic [3:0][DW-1:0] dout;
        logic [3:0]         vld;
    } vec_t;

    vec_t          tv [3];
    logic [DW-1:0] got [$];
    int            first_v;
    int            last_v;
    logic [DW-1:0] prev;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            data_in[i]     = DW'($urandom);
            destination[i] = 2'($urandom);
        end

        // Reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                data_in[i]     = DW'($urandom);
                destination[i] = 2'($urandom);
            end
            cycle("hold_reset");
            for (int j = 0; j < 4; j++) begin
                expect_eq($sformatf("reset data%0d", j), 32'(data_out[j]), 32'h0);
                expect_eq($sformatf("reset valid%0d", j), 32'(valid[j]), 32'h0);
            end
        end
        rst = 1'b1;

        // Permutation vectors
        tv[0].din  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        tv[0].dst  = {2'd3, 2'd2, 2'd1, 2'd0};
        tv[0].dout = '0;
        tv[0].vld  = 4'b0000;
        tv[1].din  = {8'h77, 8'h33, 8'hAA, 8'h55};
        tv[1].dst  = {2'd1, 2'd0, 2'd3, 2'd2};
        tv[1].dout = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        tv[1].vld  = 4'b1111;
        tv[2].din  = {8'h04, 8'h03, 8'h02, 8'h01};
        tv[2].dst  = {2'd3, 2'd2, 2'd1, 2'd0};
        tv[2].dout = {8'hAA, 8'h55, 8'h77, 8'h33};
        tv[2].vld  = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                data_in[i]     = tv[r].din[i];
                destination[i] = tv[r].dst[i];
            end
            cycle("perm");
            for (int j = 0; j < 4; j++) begin
                expect_eq($sformatf("perm r%0d data%0d", r, j),
                          32'(data_out[j]), 32'(tv[r].dout[j]));
                expect_eq($sformatf("perm r%0d valid%0d", r, j),
                          32'(valid[j]), 32'(tv[r].vld[j]));
            end
        end

        // Contention on output 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in[i]     = 8'(17 * (i + 1));
            destination[i] = 2'd0;
        end
        cycle("cont");
        for (int i = 0; i < 4; i++) begin
            data_in[i]     = 8'(i);
            destination[i] = 2'((i % 3) + 1);
        end
        got.delete();
        first_v = -1;
        last_v  = -1;
        for (int k = 0; k < 8; k++) begin
            cycle("cont");
            if (valid[0]) begin
                got.push_back(data_out[0]);
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        expect_eq("cont count", 32'(got.size()), 32'd4);
        expect_eq("cont consecutive", 32'(last_v - first_v + 1), 32'd4);
        for (int n = 0; n < 4 && n < got.size(); n++) begin
            expect_eq($sformatf("cont order%0d", n), 32'(got[n]), 32'(17 * (n + 1)));
        end

        // Overflow on input 1 while input 0 holds output 0
        do_reset();
        got.delete();
        for (int k = 0; k < 8; k++) begin
            data_in[0] = 8'(k);
            destination[0] = 2'd0;
            data_in[1] = 8'(8'h80 + k);
            destination[1] = 2'd0;
            data_in[2] = 8'h10;
            destination[2] = 2'd3;
            data_in[3] = 8'h10;
            destination[3] = 2'd3;
            cycle("ovf");
            if (valid[0] && data_out[0][7]) got.push_back(data_out[0]);
        end
        data_in[0] = 8'h20;
        destination[0] = 2'd1;
        data_in[1] = 8'h40;
        destination[1] = 2'd2;
        for (int k = 0; k < 12; k++) begin
            cycle("ovf");
            if (valid[0] && data_out[0][7]) got.push_back(data_out[0]);
        end
        prev = '0;
        for (int n = 0; n < got.size(); n++) begin
            expect_eq($sformatf("ovf inorder%0d", n), 32'(got[n] > prev), 32'd1);
            prev = got[n];
        end
`ifndef ROUTER_RR_ARB_EN
        expect_eq("ovf retained", 32'(got.size()), 32'(DEPTH));
        for (int n = 0; n < DEPTH && n < got.size(); n++) begin
            expect_eq($sformatf("ovf word%0d", n), 32'(got[n]), 32'(8'h80 + n));
        end
`endif

        // Reset pulse with buffered words
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_all(8'(8'h50 + k), 2'd0);
            cycle("midrst fill");
        end
        rst = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            expect_eq($sformatf("midrst data%0d", j), 32'(data_out[j]), 32'h0);
            expect_eq($sformatf("midrst valid%0d", j), 32'(valid[j]), 32'h0);
        end
        m_reset();
        cycle("midrst hold");
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                data_in[i]     = 8'(8'hE0 + i);
                destination[i] = 2'(i);
            end
            cycle("midrst after");
            for (int j = 0; j < 4; j++) begin
                if (valid[j]) begin
                    expect_eq($sformatf("midrst fresh%0d", j), 32'(data_out[j][7:5]), 32'h7);
                end
            end
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                data_in[i]     = DW'($urandom);
                destination[i] = (c % 50 < 10) ? 2'd2 : 2'($urandom_range(0, 3));
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
